// File: rtl/key_press_gen.sv
// Push-button emulator: drives an active-low key through a bouncing
// press, a clean hold and a bouncing release, with LFSR-timed bounces.
module key_press_gen #(
  parameter int          NUM_BOUNCE = 5,
  parameter int          GAP_W      = 8,
  parameter int          HOLD_W     = 24,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              key_out,
  output logic              busy,
  output logic              done
);

  localparam int EDGES  = 2 * NUM_BOUNCE + 1;
  localparam int EDGE_W = $clog2(EDGES + 1);
  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HOLD,
    RELEASE
  } state_t;

  state_t              state, state_n;
  logic [15:0]         lfsr, lfsr_n;
  logic [GAP_W-1:0]    gap_cnt, gap_n, gap_new;
  logic [HOLD_W-1:0]   hold_cnt, hold_n;
  logic [HOLD_W-1:0]   hold_lat, hold_lat_n, hold_in;
  logic [EDGE_W-1:0]   edge_cnt, edge_n;
  logic                key_n, busy_n, done_n;
  logic                last_edge;

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  assign gap_new = (lfsr[GAP_W-1:0] == '0) ? GAP_W'(1) : lfsr[GAP_W-1:0];
  assign hold_in = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;

  assign last_edge = (edge_cnt == EDGE_W'(EDGES - 1));

  always_comb begin
    state_n    = state;
    gap_n      = gap_cnt;
    hold_n     = hold_cnt;
    hold_lat_n = hold_lat;
    edge_n     = edge_cnt;
    key_n      = key_out;
    busy_n     = busy;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          key_n      = 1'b0;
          busy_n     = 1'b1;
          edge_n     = EDGE_W'(1);
          gap_n      = gap_new;
          hold_lat_n = hold_in;
          hold_n     = hold_in;
          state_n    = (EDGES == 1) ? HOLD : PRESS;
        end
      end
      PRESS: begin
        if (gap_cnt <= GAP_W'(1)) begin
          key_n  = ~key_out;
          edge_n = edge_cnt + EDGE_W'(1);
          gap_n  = gap_new;
          if (last_edge) begin
            hold_n  = hold_lat;
            state_n = HOLD;
          end
        end else begin
          gap_n = gap_cnt - GAP_W'(1);
        end
      end
      HOLD: begin
        if (hold_cnt <= HOLD_W'(1)) begin
          key_n  = 1'b1;
          edge_n = EDGE_W'(1);
          gap_n  = gap_new;
          // A clean key has a single release edge, which is also the last
          if (EDGES == 1) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = RELEASE;
          end
        end else begin
          hold_n = hold_cnt - HOLD_W'(1);
        end
      end
      RELEASE: begin
        if (gap_cnt <= GAP_W'(1)) begin
          key_n  = ~key_out;
          edge_n = edge_cnt + EDGE_W'(1);
          gap_n  = gap_new;
          if (last_edge) begin
            key_n   = 1'b1;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lfsr     <= SEED;
      gap_cnt  <= '0;
      hold_cnt <= '0;
      hold_lat <= '0;
      edge_cnt <= '0;
      key_out  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      lfsr     <= lfsr_n;
      gap_cnt  <= gap_n;
      hold_cnt <= hold_n;
      hold_lat <= hold_lat_n;
      edge_cnt <= edge_n;
      key_out  <= key_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule
